// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding one shared 8N1 UART transmitter.
// Each frame takes one requester's byte. The frame is timed by an external baud
// generator that this block enables with bps_start.
// Ports:
//   clk, rst     - system clock; synchronous active-high reset
//   req          - per-requester byte-pending level, held until acked
//   tx_data      - requester i byte on tx_data[8i+7:8i], sampled on the grant edge
//   clk_bps      - one-cycle baud tick from the shared generator
//   bps_start    - baud generator enable, high for the whole frame
//   ack          - one-hot one-cycle pulse when a byte is latched
//   grant_id     - index of the current/last granted requester
//   busy         - high from grant until frame end
//   frame_done   - one-cycle pulse at frame end
//   uart_tx      - serial line
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ    = 4,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       tx_data,
    input  logic                       clk_bps,
    output logic                       bps_start,
    output logic [NUM_REQ-1:0]         ack,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       uart_tx
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, SYNC, SEND} state_t;

    state_t             state, state_n;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [7:0]         shift, shift_n;
    logic               uart_tx_n, bps_start_n, busy_n, frame_done_n;
    logic [NUM_REQ-1:0] ack_n;
    logic [ID_W-1:0]    grant_id_n;

    logic               found;
    logic [ID_W-1:0]    sel;

    // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        found = 1'b0;
        sel   = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [ID_W-1:0] idx;
            idx = rr_ptr + ID_W'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_n      = state;
        uart_tx_n    = uart_tx;
        bps_start_n  = bps_start;
        ack_n        = '0;
        grant_id_n   = grant_id;
        busy_n       = busy;
        frame_done_n = 1'b0;
        rr_ptr_n     = rr_ptr;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;

        case (state)
            IDLE: begin
                uart_tx_n   = IDLE_LEVEL;
                bps_start_n = 1'b0;
                if (found) begin
                    shift_n     = tx_data[{sel, 3'b000} +: 8];
                    grant_id_n  = sel;
                    ack_n[sel]  = 1'b1;
                    busy_n      = 1'b1;
                    bps_start_n = 1'b1;
                    state_n     = SYNC;
                end
            end
            // First tick only realigns to the generator's phase; start bit begins here
            SYNC: begin
                if (clk_bps) begin
                    uart_tx_n = 1'b0;
                    bit_cnt_n = CNT_W'(1);
                    state_n   = SEND;
                end
            end
            SEND: begin
                if (clk_bps) begin
                    if (bit_cnt <= CNT_W'(8)) begin
                        uart_tx_n = shift[0];
                        shift_n   = {1'b0, shift[7:1]};
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end else if (bit_cnt == CNT_W'(9)) begin
                        uart_tx_n = 1'b1;
                        bit_cnt_n = CNT_W'(10);
                    end else begin
                        // Stop bit has lasted a full tick period
                        bps_start_n  = 1'b0;
                        busy_n       = 1'b0;
                        frame_done_n = 1'b1;
                        rr_ptr_n     = grant_id + ID_W'(1);
                        state_n      = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            uart_tx    <= IDLE_LEVEL;
            bps_start  <= 1'b0;
            ack        <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            rr_ptr     <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
        end else begin
            state      <= state_n;
            uart_tx    <= uart_tx_n;
            bps_start  <= bps_start_n;
            ack        <= ack_n;
            grant_id   <= grant_id_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
            rr_ptr     <= rr_ptr_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus queues expected grants,
// a monitor decodes the line and checks each frame against the queue.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] tx_data;
    logic        clk_bps;
    logic        bps_start;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic        busy;
    logic        frame_done;
    logic        uart_tx;

    uart_tx_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .tx_data    (tx_data),
        .clk_bps    (clk_bps),
        .bps_start  (bps_start),
        .ack        (ack),
        .grant_id   (grant_id),
        .busy       (busy),
        .frame_done (frame_done),
        .uart_tx    (uart_tx)
    );

    always #10 clk = ~clk;

    // mode: 0 no latency check, 1 ack one cycle after req set, 2 ack one cycle after frame_done
    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic [1:0] mode;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   req_cyc     = 0;
    int   done_cyc    = 0;
    logic extra_pulse = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Baud generator model: first tick 8 clk after enable, then every 16 clk
    initial begin : baud_gen
        int bcnt;
        bcnt    = 0;
        clk_bps = 1'b0;
        forever begin
            @(negedge clk);
            if (bps_start !== 1'b1) begin
                bcnt    = 0;
                clk_bps = extra_pulse;
            end else begin
                bcnt++;
                clk_bps = ((bcnt >= 8) && (((bcnt - 8) % 16) == 0)) || extra_pulse;
            end
        end
    end

    // Monitor: pops on ack, decodes the frame, checks it at frame_done
    initial begin : monitor
        exp_t       cur;
        logic       active, idle_bad, ctl_bad, extra_ack;
        logic       bits [10];
        int         dur  [10];
        int         idx;
        logic [7:0] data;
        active    = 1'b0;
        idle_bad  = 1'b0;
        ctl_bad   = 1'b0;
        extra_ack = 1'b0;
        idx       = -1;
        cur       = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("reset_outs", 32'({uart_tx, bps_start, busy, ack, frame_done, grant_id}),
                      32'b10_0000_0000);
                active   = 1'b0;
                idle_bad = 1'b0;
            end else if (!active) begin
                if (ack != 4'b0000) begin
                    check("idle_line", 32'(idle_bad), 32'd0);
                    idle_bad = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", 32'(ack), 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("ack_onehot", 32'(ack), 32'(4'b0001 << cur.id));
                        check("grant_id", 32'(grant_id), 32'(cur.id));
                        if (cur.mode == 2'd1) check("grant_latency", 32'(cyc - req_cyc), 32'd1);
                        if (cur.mode == 2'd2) check("b2b_latency", 32'(cyc - done_cyc), 32'd1);
                        check("grant_outs", 32'({uart_tx, busy, bps_start}), 32'b111);
                        active    = 1'b1;
                        idx       = -1;
                        ctl_bad   = 1'b0;
                        extra_ack = 1'b0;
                        for (int k = 0; k < 10; k++) begin
                            dur[k]  = 0;
                            bits[k] = 1'bx;
                        end
                    end
                end else if (uart_tx !== 1'b1 || bps_start !== 1'b0 || busy !== 1'b0 ||
                             frame_done !== 1'b0) begin
                    idle_bad = 1'b1;
                end
            end else if (frame_done) begin
                check("frame_bits", 32'(idx), 32'd9);
                check("start_bit", 32'(bits[0]), 32'd0);
                check("stop_bit", 32'(bits[9]), 32'd1);
                for (int k = 0; k < 8; k++) data[k] = bits[k + 1];
                check("data_byte", 32'(data), 32'(cur.data));
                for (int k = 0; k < 10; k++) check("bit_len", 32'(dur[k]), 32'd16);
                check("end_outs", 32'({uart_tx, busy, bps_start, ack}), 32'b100_0000);
                check("frame_ctl", 32'(ctl_bad), 32'd0);
                check("extra_ack", 32'(extra_ack), 32'd0);
                active   = 1'b0;
                done_cyc = cyc;
            end else begin
                if (ack != 4'b0000) extra_ack = 1'b1;
                if (busy !== 1'b1 || bps_start !== 1'b1) ctl_bad = 1'b1;
                if (clk_bps) begin
                    idx++;
                    if (idx < 10) begin
                        bits[idx] = uart_tx;
                        dur[idx]  = 1;
                    end else begin
                        ctl_bad = 1'b1;
                    end
                end else if (idx < 0) begin
                    if (uart_tx !== 1'b1) ctl_bad = 1'b1;
                end else if (idx < 10) begin
                    dur[idx]++;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_req(input logic [3:0] v);
        req     = v;
        req_cyc = cyc;
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] d, input logic [1:0] mode);
        exp_q.push_back({id, d, mode});
        tx_data[8*id +: 8] = d;
    endtask

    task automatic wait_ack(output logic [3:0] a);
        a = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #2;
            if (ack != 4'b0000) break;
        end
        a = ack;
        check("ack_wait", 32'(ack != 4'b0000), 32'd1);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #2;
            if (frame_done) break;
        end
        check("done_wait", 32'(frame_done), 32'd1);
    endtask

    task automatic wait_pulses(input int np);
        int seen;
        seen = 0;
        for (int n = 0; n < 400 && seen < np; n++) begin
            @(posedge clk);
            #2;
            if (clk_bps) seen++;
        end
        check("pulse_wait", 32'(seen), 32'(np));
    endtask

    // Serve a single requester and drop its req after the ack
    task automatic single(input logic [1:0] id, input logic [7:0] d);
        logic [3:0] a;
        push(id, d, 2'd1);
        set_req(4'b0001 << id);
        wait_ack(a);
        req = req & ~a;
        wait_done();
    endtask

    initial begin : stimulus
        logic [3:0] a;
        rst     = 1'b1;
        req     = 4'b0000;
        tx_data = 32'h0;
        cycles(3);
        rst = 1'b0;
        cycles(2);

        // Single byte 0x55 from requester 0
        single(2'd0, 8'h55);
        cycles(3);

        // Move rr_ptr back to 0, then all four held: order 0,1,2,3,0
        single(2'd3, 8'h3C);
        cycles(2);
        push(2'd0, 8'hA0, 2'd1);
        push(2'd1, 8'hA1, 2'd2);
        push(2'd2, 8'hA2, 2'd2);
        push(2'd3, 8'hA3, 2'd2);
        exp_q.push_back({2'd0, 8'hA0, 2'd2});
        set_req(4'b1111);
        for (int k = 0; k < 5; k++) wait_ack(a);
        req = 4'b0000;
        wait_done();
        cycles(2);

        // Serve 1 (rr_ptr becomes 2), then 0 and 1 together: 0 goes first
        single(2'd1, 8'h96);
        cycles(2);
        push(2'd0, 8'h0F, 2'd1);
        push(2'd1, 8'hF0, 2'd2);
        set_req(4'b0011);
        wait_ack(a);
        req = req & ~a;
        wait_ack(a);
        req = req & ~a;
        wait_done();
        cycles(2);

        // Abort a frame from requester 3 during data bit 4; rr_ptr must return to 0
        push(2'd3, 8'hC3, 2'd1);
        set_req(4'b1000);
        wait_ack(a);
        req = req & ~a;
        wait_pulses(6);
        cycles(4);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(3);
        push(2'd0, 8'h12, 2'd1);
        push(2'd2, 8'h34, 2'd2);
        set_req(4'b0101);
        wait_ack(a);
        req = req & ~a;
        wait_ack(a);
        req = req & ~a;
        wait_done();
        cycles(2);
        single(2'd2, 8'hE7);
        cycles(2);

        // Ticks while idle are ignored, as is one on the grant edge
        extra_pulse = 1'b1;
        cycles(3);
        extra_pulse = 1'b0;
        cycles(2);
        push(2'd0, 8'h81, 2'd1);
        extra_pulse = 1'b1;
        set_req(4'b0001);
        cycles(1);
        extra_pulse = 1'b0;
        req         = 4'b0000;
        wait_done();
        cycles(2);

        // Data changed after ack and req held: old byte sent, then re-served with new byte
        push(2'd1, 8'h5A, 2'd1);
        exp_q.push_back({2'd1, 8'hA5, 2'd2});
        set_req(4'b0010);
        wait_ack(a);
        tx_data[15:8] = 8'hA5;
        wait_done();
        wait_ack(a);
        req = 4'b0000;
        wait_done();
        cycles(4);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
